// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions used by the HI/LO multiply/divide unit.
package mips_cpu_pkg;

   localparam int MULDIV_ITERS = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } muldiv_state_t;

   // Unsigned magnitude of a two's-complement word; 0x80000000 maps to itself.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the HI/LO multiply/divide unit.
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, operand_a, operand_b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 33-cycle multiply/divide unit owning the HI/LO pair; one product or
// quotient bit per cycle on unsigned magnitudes, sign fixed up in a final cycle.
module mult_div_unit
   import mips_cpu_pkg::*;
(
   input logic            clk,
   input logic            reset_n,
   mult_div_unit_if.slave bus
);

   localparam logic [4:0] LAST_COUNT = 5'(MULDIV_ITERS - 1);

   muldiv_state_t state_q, state_d;
   logic [4:0]    count_q, count_d;
   logic [63:0]   acc_q, acc_d;
   logic [31:0]   mcand_q, mcand_d;
   logic [31:0]   mplier_q, mplier_d;
   logic          qsign_q, qsign_d;
   logic          rsign_q, rsign_d;
   logic          is_div_q, is_div_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic          signed_op;
   logic [32:0]   add_sum;
   logic [32:0]   trial;
   logic [63:0]   product;

   // Multiply keeps the partial product in acc and shifts it right; divide keeps
   // {remainder, dividend/quotient} in acc and shifts it left.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      qsign_d   = qsign_q;
      rsign_d   = rsign_q;
      is_div_d  = is_div_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      signed_op = 1'b0;
      add_sum   = {1'b0, acc_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};
      trial     = {acc_q[63:32], acc_q[31]} - {1'b0, mcand_q};
      product   = qsign_q ? -acc_q : acc_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_MULT, OP_MULTU: begin
                     signed_op = (bus.op == OP_MULT);
                     mcand_d   = signed_op ? abs32(bus.operand_a) : bus.operand_a;
                     mplier_d  = signed_op ? abs32(bus.operand_b) : bus.operand_b;
                     qsign_d   = signed_op & (bus.operand_a[31] ^ bus.operand_b[31]);
                     rsign_d   = 1'b0;
                     is_div_d  = 1'b0;
                     acc_d     = 64'd0;
                     count_d   = 5'd0;
                     busy_d    = 1'b1;
                     state_d   = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     signed_op = (bus.op == OP_DIV);
                     mcand_d   = signed_op ? abs32(bus.operand_b) : bus.operand_b;
                     acc_d     = {32'd0, (signed_op ? abs32(bus.operand_a) : bus.operand_a)};
                     qsign_d   = signed_op & (bus.operand_a[31] ^ bus.operand_b[31]);
                     rsign_d   = signed_op & bus.operand_a[31];
                     is_div_d  = 1'b1;
                     count_d   = 5'd0;
                     busy_d    = 1'b1;
                     state_d   = DIV;
                  end
                  OP_MTHI: hi_d = bus.operand_a;
                  OP_MTLO: lo_d = bus.operand_a;
                  default: ;
               endcase
            end
         end
         MUL: begin
            acc_d    = {add_sum, acc_q[31:1]};
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 5'd1;
            if (count_q == LAST_COUNT) state_d = FIX;
         end
         DIV: begin
            // A zero divisor always subtracts, yielding all-ones quotient and the dividend as remainder.
            if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
            else            acc_d = {acc_q[62:0], 1'b0};
            count_d = count_q + 5'd1;
            if (count_q == LAST_COUNT) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               lo_d = qsign_q ? -acc_q[31:0]  : acc_q[31:0];
               hi_d = rsign_q ? -acc_q[63:32] : acc_q[63:32];
            end else begin
               hi_d = product[63:32];
               lo_d = product[31:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= 5'd0;
         acc_q    <= 64'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         is_div_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
         is_div_q <= is_div_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
   import mips_cpu_pkg::*;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mult_div_unit_if bus();

   mult_div_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not terminate");
   end

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference result {hi,lo} computed from plain signed/unsigned arithmetic.
   function automatic logic [63:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] cur);
      longint      sa, sb, sp;
      logic [63:0] up;
      logic [31:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MULT: begin
            sp = sa * sb;
            return 64'(sp);
         end
         OP_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            return up;
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
               r = a;
            end else begin
               q = 32'(sa / sb);
               r = 32'(sa % sb);
            end
            return {r, q};
         end
         OP_DIVU: begin
            if (b == 32'd0) begin
               q = 32'hFFFF_FFFF;
               r = a;
            end else begin
               q = a / b;
               r = a % b;
            end
            return {r, q};
         end
         OP_MTHI: return {a, cur[31:0]};
         OP_MTLO: return {cur[63:32], a};
         default: return cur;
      endcase
   endfunction

   function automatic bit is_long_op(input logic [2:0] op);
      return op <= 3'd3;
   endfunction

   task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // Waits out the remaining cycles of a long op, checking latency, busy and result.
   task automatic finish_op(input string tag, input logic [63:0] expected, input int remaining);
      int n;
      int busy_cnt;
      n = 0;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(negedge clk);
         n++;
      end
      check_output({tag, "_latency"}, 64'(n), 64'(remaining));
      check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(remaining));
      check_output({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      check_output({tag, "_result"}, {bus.hi, bus.lo}, expected);
   endtask

   task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit in_done_cycle);
      logic [63:0] expected;
      expected = model_op(op, a, b, {hi_m, lo_m});
      if (!in_done_cycle) @(negedge clk);
      issue_now(op, a, b);
      if (is_long_op(op)) begin
         check_output({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
         finish_op(tag, expected, 33);
      end else begin
         check_output({tag, "_busy_short"}, 64'(bus.busy), 64'd0);
         check_output({tag, "_done_short"}, 64'(bus.done), 64'd0);
         check_output({tag, "_hilo"}, {bus.hi, bus.lo}, expected);
      end
      hi_m = expected[63:32];
      lo_m = expected[31:0];
   endtask

   initial begin
      logic [63:0] expected;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      checks        = 0;
      errors        = 0;
      hi_m          = 32'd0;
      lo_m          = 32'd0;
      bus.start     = 1'b0;
      bus.op        = 3'd0;
      bus.operand_a = 32'd0;
      bus.operand_b = 32'd0;
      reset_n       = 1'b0;

      repeat (2) @(negedge clk);
      check_output("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      check_output("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      reset_n = 1'b1;

      apply_stimulus("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check_output("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      @(negedge clk);
      check_output("done_single_pulse", 64'(bus.done), 64'd0);

      apply_stimulus("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
      check_output("mult_neg3x7_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      apply_stimulus("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
      check_output("mult_minsq_const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
      apply_stimulus("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check_output("div_neg7by2_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      apply_stimulus("divu_100by7", OP_DIVU, 32'd100, 32'd7, 1'b0);
      check_output("divu_100by7_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
      apply_stimulus("divu_by0", OP_DIVU, 32'd5, 32'd0, 1'b0);
      check_output("divu_by0_const", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
      apply_stimulus("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check_output("div_overflow_const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
      apply_stimulus("div_neg_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);

      // MTHI then MTLO on consecutive cycles.
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_MTHI; bus.operand_a = 32'h1234_5678;
      @(negedge clk);
      check_output("mthi_visible", 64'(bus.hi), 64'h1234_5678);
      check_output("mthi_busy", 64'(bus.busy), 64'd0);
      bus.op = OP_MTLO; bus.operand_a = 32'h9ABC_DEF0;
      @(negedge clk);
      bus.start = 1'b0;
      check_output("mtlo_visible", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
      check_output("mtlo_busy", 64'(bus.busy), 64'd0);
      hi_m = 32'h1234_5678;
      lo_m = 32'h9ABC_DEF0;

      // MTLO issued in the middle of a DIV must be ignored.
      expected = model_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, {hi_m, lo_m});
      @(negedge clk);
      issue_now(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
      repeat (9) @(negedge clk);
      issue_now(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
      check_output("ignored_mtlo_lo", 64'(bus.lo), 64'(lo_m));
      check_output("ignored_mtlo_busy", 64'(bus.busy), 64'd1);
      finish_op("div_with_ignored", expected, 23);
      hi_m = expected[63:32];
      lo_m = expected[31:0];

      // Asynchronous reset in the middle of a MULT.
      @(negedge clk);
      issue_now(OP_MULT, 32'hFFFF_1234, 32'h0000_5678);
      repeat (14) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
      check_output("midop_reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      apply_stimulus("divu_after_reset", OP_DIVU, 32'd9, 32'd3, 1'b0);
      check_output("divu_after_reset_const", {bus.hi, bus.lo}, {32'd0, 32'd3});

      // Back-to-back: second MULTU issued in the done cycle of the first.
      apply_stimulus("b2b_first", OP_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b0);
      check_output("b2b_first_done", 64'(bus.done), 64'd1);
      apply_stimulus("b2b_second", OP_MULTU, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1);

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: ra = 32'h8000_0000;
            2: rb = 32'($urandom_range(1, 15));
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         apply_stimulus("random", rop, ra, rb, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
